// File: rtl/mux_nx1_rr_pkg.sv
// mux_nx1_rr shared package
// mode encodings and select-width helper
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int sel_w(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nx1_rr_if.sv
// mux_nx1_rr channel/output bundle
// master drives inputs, slave is the mux
interface mux_nx1_rr_if
  import mux_pkg::*;
#(
  parameter int N_CH  = 10,
  parameter int WIDTH = 8
);

  localparam int SEL_W = sel_w(N_CH);

  logic [N_CH*WIDTH-1:0] din;
  logic [N_CH-1:0]       din_valid;
  logic [N_CH-1:0]       din_ready;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_valid;
  logic                  out_ready;
  logic                  sel_err;

  modport master (
    output din, din_valid, mode,
    output sel, out_ready,
    input  din_ready, out_data,
    input  out_ch, out_valid, sel_err
  );

  modport slave (
    input  din, din_valid, mode,
    input  sel, out_ready,
    output din_ready, out_data,
    output out_ch, out_valid, sel_err
  );

endinterface

// File: rtl/mux_nx1_rr_arb.sv
// rr_arbiter: combinational round-robin pick
// first req at or after ptr, wrapping
module rr_arbiter #(
  parameter int N  = 10,
  parameter int SW = 4
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx
);

  logic [2*N-1:0] dreq;
  logic           found;

  assign dreq = {req, req};

  // masked scan over the doubled request vector
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int j = 0; j < 2*N; j++) begin
      if (!found && j >= int'(ptr)
          && dreq[j]) begin
        found       = 1'b1;
        gnt[j % N]  = 1'b1;
        idx         = SW'(j % N);
      end
    end
  end

endmodule

// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr: N:1 registered channel mux
// fixed-select or round-robin, valid/ready
module mux_nx1_rr
  import mux_pkg::*;
#(
  parameter int N_CH  = 10,
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_nx1_rr_if.slave  bus
);

  localparam int SEL_W = sel_w(N_CH);

  logic [N_CH-1:0]  gnt_rr;
  logic [N_CH-1:0]  gnt_fix;
  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] idx_rr;
  logic [SEL_W-1:0] gidx;
  logic [SEL_W-1:0] ptr;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] ch_q;
  logic             valid_q;
  logic             err_q;
  logic             sel_ok;
  logic             load_en;
  logic             xfer;

  assign sel_ok  = int'(bus.sel) < N_CH;
  assign load_en = !valid_q || bus.out_ready;

  rr_arbiter #(
    .N  (N_CH),
    .SW (SEL_W)
  ) u_arb (
    .req (bus.din_valid),
    .ptr (ptr),
    .gnt (gnt_rr),
    .idx (idx_rr)
  );

  // fixed-select grant, none when sel is out of range
  always_comb begin
    gnt_fix = '0;
    for (int i = 0; i < N_CH; i++) begin
      gnt_fix[i] = sel_ok
        && (int'(bus.sel) == i)
        && bus.din_valid[i];
    end
  end

  // choose grant source by mode
  always_comb begin
    grant = gnt_fix;
    gidx  = bus.sel;
    if (bus.mode == MODE_RR) begin
      grant = gnt_rr;
      gidx  = idx_rr;
    end
  end

  assign bus.din_ready = rst_n
    ? (grant & {N_CH{load_en}})
    : '0;
  assign xfer = |bus.din_ready;

  // AND-OR data select over one-hot grant
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel_data |= bus.din[i*WIDTH +: WIDTH]
        & {WIDTH{grant[i]}};
    end
  end

  // output register: load on transfer, drain on ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else if (xfer) begin
      data_q  <= sel_data;
      ch_q    <= gidx;
      valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // round-robin pointer moves past each RR winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer && bus.mode == MODE_RR) begin
      ptr <= (int'(gidx) == N_CH-1)
        ? '0 : gidx + 1'b1;
    end
  end

  // one-cycle flag for out-of-range fixed select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (bus.mode == MODE_FIXED)
        && !sel_ok;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;
  assign bus.sel_err   = err_q;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// tb_mux_nx1_rr: directed vectors + scoreboard
// for the N:1 round-robin mux
module tb_mux_nx1_rr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mux_nx1_rr_if #(.N_CH(10), .WIDTH(8)) bus ();

  mux_nx1_rr #(
    .N_CH  (10),
    .WIDTH (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       mode;
    logic [3:0] sel;
    logic [9:0] dv;
    logic       ordy;
    logic [9:0] e_rdy;
    logic       e_ov;
    logic [3:0] e_ch;
    logic [7:0] e_data;
    logic       e_err;
  } vec_t;

  vec_t tbl [20];

  typedef struct {
    logic [3:0] ch;
    logic [7:0] data;
  } word_t;

  word_t q [$];

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h",
               name, act, exp);
    end
  endtask

  function automatic logic [7:0] ch_data(int i);
    logic [7:0] b;
    b = 8'h30 + 8'(i);
    return (i == 9) ? 8'hA5 : b;
  endfunction

  function automatic vec_t mk(
    logic m, logic [3:0] s, logic [9:0] dv,
    logic r, logic [9:0] er, logic ov,
    logic [3:0] ch, logic err);
    vec_t v;
    v.mode = m; v.sel = s; v.dv = dv;
    v.ordy = r; v.e_rdy = er; v.e_ov = ov;
    v.e_ch = ch; v.e_data = ch_data(int'(ch));
    v.e_err = err;
    return v;
  endfunction

  // scoreboard: accepted words leave in order, once
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_word", 32'd1, 32'd0);
        end else begin
          word_t w;
          w = q.pop_front();
          chk("sb_ch", 32'(bus.out_ch), 32'(w.ch));
          chk("sb_data", 32'(bus.out_data),
              32'(w.data));
        end
      end
      for (int i = 0; i < 10; i++) begin
        if (bus.din_valid[i] && bus.din_ready[i]) begin
          word_t w;
          w.ch = 4'(i);
          w.data = bus.din[i*8 +: 8];
          q.push_back(w);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 10; i++)
      bus.din[i*8 +: 8] = ch_data(i);
    bus.din_valid = '0;
    bus.mode = 1'b0;
    bus.sel = '0;
    bus.out_ready = 1'b1;

    // reset held while inputs toggle
    for (int c = 0; c < 4; c++) begin
      bus.din_valid = 10'($urandom);
      bus.mode = 1'($urandom);
      bus.sel = 4'($urandom);
      bus.out_ready = 1'($urandom);
      #1;
      chk("rst_din_ready", 32'(bus.din_ready), 0);
      tick();
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_data", 32'(bus.out_data), 0);
      chk("rst_sel_err", 32'(bus.sel_err), 0);
    end
    rst_n = 1'b1;

    tbl[0]  = mk(0, 9, 10'h200, 1, 10'h200, 1, 9, 0);
    tbl[1]  = mk(0, 12, 10'h3FF, 0, 10'h000, 1, 9, 1);
    tbl[2]  = mk(0, 3, 10'h008, 1, 10'h008, 1, 3, 0);
    tbl[3]  = mk(0, 3, 10'h000, 1, 10'h000, 0, 3, 0);
    tbl[4]  = mk(1, 0, 10'h209, 1, 10'h001, 1, 0, 0);
    tbl[5]  = mk(1, 0, 10'h209, 1, 10'h008, 1, 3, 0);
    tbl[6]  = mk(1, 0, 10'h209, 1, 10'h200, 1, 9, 0);
    tbl[7]  = mk(1, 0, 10'h209, 1, 10'h001, 1, 0, 0);
    tbl[8]  = mk(1, 0, 10'h209, 1, 10'h008, 1, 3, 0);
    tbl[9]  = mk(1, 0, 10'h209, 0, 10'h000, 1, 3, 0);
    tbl[10] = mk(1, 0, 10'h209, 0, 10'h000, 1, 3, 0);
    tbl[11] = mk(1, 0, 10'h209, 0, 10'h000, 1, 3, 0);
    tbl[12] = mk(1, 0, 10'h209, 0, 10'h000, 1, 3, 0);
    tbl[13] = mk(1, 0, 10'h209, 1, 10'h200, 1, 9, 0);
    tbl[14] = mk(1, 0, 10'h3FF, 1, 10'h001, 1, 0, 0);
    tbl[15] = mk(0, 5, 10'h3FF, 1, 10'h020, 1, 5, 0);
    tbl[16] = mk(1, 0, 10'h3FF, 1, 10'h002, 1, 1, 0);
    tbl[17] = mk(1, 0, 10'h3FF, 1, 10'h004, 1, 2, 0);
    tbl[18] = mk(1, 0, 10'h000, 1, 10'h000, 0, 2, 0);
    tbl[19] = mk(1, 0, 10'h001, 1, 10'h001, 1, 0, 0);

    for (int k = 0; k < 20; k++) begin
      bus.mode = tbl[k].mode;
      bus.sel = tbl[k].sel;
      bus.din_valid = tbl[k].dv;
      bus.out_ready = tbl[k].ordy;
      #1;
      chk($sformatf("v%0d_din_ready", k),
          32'(bus.din_ready), 32'(tbl[k].e_rdy));
      tick();
      chk($sformatf("v%0d_out_valid", k),
          32'(bus.out_valid), 32'(tbl[k].e_ov));
      chk($sformatf("v%0d_out_ch", k),
          32'(bus.out_ch), 32'(tbl[k].e_ch));
      chk($sformatf("v%0d_out_data", k),
          32'(bus.out_data), 32'(tbl[k].e_data));
      chk($sformatf("v%0d_sel_err", k),
          32'(bus.sel_err), 32'(tbl[k].e_err));
    end

    // reset mid-stream, ptr currently 1
    bus.mode = 1'b1;
    bus.din_valid = 10'h3FF;
    bus.out_ready = 1'b1;
    #1;
    chk("mid_din_ready", 32'(bus.din_ready), 32'h002);
    tick();
    chk("mid_out_ch", 32'(bus.out_ch), 1);
    chk("mid_out_valid", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 0);
    chk("arst_out_data", 32'(bus.out_data), 0);
    chk("arst_din_ready", 32'(bus.din_ready), 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_din_ready", 32'(bus.din_ready), 32'h001);

    // full sweep with wrap from 9 to 0
    for (int i = 0; i < 11; i++) begin
      tick();
      chk($sformatf("sweep%0d_ch", i),
          32'(bus.out_ch), 32'(i % 10));
      chk($sformatf("sweep%0d_data", i),
          32'(bus.out_data), 32'(ch_data(i % 10)));
    end

    // drain and confirm nothing left behind
    bus.din_valid = '0;
    tick();
    chk("drain_out_valid", 32'(bus.out_valid), 0);
    tick();
    chk("sb_empty", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
